// File: rtl/spm_seq_mult.sv
// Serial-parallel multiplier: x is held across a chain of per-bit carry-save cells,
// y is streamed in LSB first and the 2*SIZE-bit product emerges serially from stage 0.
module spm_seq_mult #(
    parameter int SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     x,
    input  logic [SIZE-1:0]     y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   product,
    output logic                p_serial,
    output logic                p_serial_valid,
    output logic                busy
);
    localparam int PW = 2 * SIZE;
    localparam int CW = $clog2(PW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [SIZE-1:0] x_reg, y_shift;
    logic [CW-1:0]   count;
    logic [PW-2:0]   prod_sr;
    logic [SIZE-1:0] fa_sum, sum_q;
    logic            accept, run, last, ybit;

    assign accept = (state == IDLE) && in_valid;
    assign run    = (state == RUN);
    assign last   = run && (count == CW'(PW - 1));
    // Once all multiplier bits are in, the chain keeps running on zeros to flush carries.
    assign ybit   = (count < CW'(SIZE)) && y_shift[0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Stage i adds its partial product, the sum from stage i+1 and its own carry.
    for (genvar i = 0; i < SIZE; i++) begin : g_stage
        logic sum_in, pp, carry_q;
        if (i == SIZE - 1) begin : g_top
            assign sum_in = 1'b0;
        end else begin : g_mid
            assign sum_in = sum_q[i+1];
        end
        assign pp        = x_reg[i] & ybit;
        assign fa_sum[i] = pp ^ sum_in ^ carry_q;
        always_ff @(posedge clk) begin
            if (rst || accept) carry_q <= 1'b0;
            else if (run)      carry_q <= (pp & sum_in) | (pp & carry_q) | (sum_in & carry_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) sum_q <= '0;
        else if (run)      sum_q <= fa_sum;
    end

    // The registered stage-0 sum is exactly the last product bit emitted.
    assign p_serial = sum_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg          <= '0;
            y_shift        <= '0;
            count          <= '0;
            prod_sr        <= '0;
            product        <= '0;
            p_serial_valid <= 1'b0;
        end else begin
            p_serial_valid <= run;
            if (accept) begin
                x_reg   <= x;
                y_shift <= y;
                count   <= '0;
                prod_sr <= '0;
            end else if (run) begin
                y_shift <= y_shift >> 1;
                count   <= count + CW'(1);
                prod_sr <= {fa_sum[0], prod_sr[PW-2:1]};
                if (last) product <= {fa_sum[0], prod_sr};
            end
        end
    end
endmodule

// File: tb/tb_spm_seq_mult.sv
// Directed bench for spm_seq_mult (SIZE=32): latency, serial stream, DONE hold,
// mid-run reset and a tied-handshake random run against an x*y model.
module tb_spm_seq_mult;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic        in_ready, out_valid, p_serial, p_serial_valid, busy;
    logic [31:0] x, y;
    logic [63:0] product;

    int n_chk = 0;
    int n_pass = 0;

    spm_seq_mult #(.SIZE(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .p_serial(p_serial), .p_serial_valid(p_serial_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic accept(input logic [31:0] xa, input logic [31:0] ya);
        in_valid = 1'b1;
        x = xa;
        y = ya;
        tick();
        in_valid = 1'b0;
        x = $urandom;
        y = $urandom;
    endtask

    // Edges are counted from the acceptance edge itself (edges=1 on entry).
    task automatic wait_done(output int edges, output logic [63:0] stream, output int nbits);
        edges = 1;
        nbits = 0;
        stream = '0;
        while (!out_valid && edges < 200) begin
            tick();
            edges++;
            if (p_serial_valid) begin
                if (nbits < 64) stream[nbits] = p_serial;
                nbits++;
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int          edges, nbits, cyc, last_acc, acc, done, ov_seen;
        logic [63:0] stream, exp;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_pvalid", p_serial_valid, 0);
        chk("rst_pserial", p_serial, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);

        // 3 * 5
        accept(32'd3, 32'd5);
        chk("t1_in_ready_drop", in_ready, 0);
        chk("t1_busy", busy, 1);
        wait_done(edges, stream, nbits);
        chk("t1_latency", 64'(edges), 65);
        chk("t1_product", product, 64'd15);
        chk("t1_stream", stream, 64'd15);
        chk("t1_nbits", 64'(nbits), 64);
        release_out();
        chk("t1_out_valid_drop", out_valid, 0);
        chk("t1_in_ready_back", in_ready, 1);
        chk("t1_pvalid_off", p_serial_valid, 0);

        // all ones, then hold DONE with in_valid/x/y toggling
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(edges, stream, nbits);
        chk("t2_product", product, 64'hFFFF_FFFE_0000_0001);
        chk("t2_stream", stream, 64'hFFFF_FFFE_0000_0001);
        chk("t2_nbits", 64'(nbits), 64);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            x = $urandom;
            y = $urandom;
            tick();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_product", product, 64'hFFFF_FFFE_0000_0001);
        end
        chk("hold_pvalid", p_serial_valid, 0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("hold_out_valid_drop", out_valid, 0);
        chk("hold_in_ready_back", in_ready, 1);
        tick();
        chk("hold_no_accept", busy, 0);

        // zero operand and top-bit operand
        accept(32'h0, 32'hDEAD_BEEF);
        wait_done(edges, stream, nbits);
        chk("t3_product", product, 64'h0);
        release_out();
        accept(32'h8000_0000, 32'd2);
        wait_done(edges, stream, nbits);
        chk("t4_product", product, 64'h1_0000_0000);
        chk("t4_stream", stream, 64'h1_0000_0000);
        release_out();

        // reset while RUN counter = 20
        accept(32'd5, 32'd5);
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_product", product, 0);
        chk("mid_rst_pvalid", p_serial_valid, 0);
        chk("mid_rst_pserial", p_serial, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        chk("mid_rst_no_out_valid", 64'(ov_seen), 0);
        accept(32'd7, 32'd9);
        wait_done(edges, stream, nbits);
        chk("t5_product", product, 64'd63);
        chk("t5_latency", 64'(edges), 65);
        release_out();

        // tied handshakes, random operands
        out_ready = 1'b1;
        in_valid = 1'b1;
        x = $urandom;
        y = $urandom;
        cyc = 0; last_acc = 0; acc = 0; done = 0; exp = '0;
        while (done < 1000 && cyc < 70000) begin
            if (in_ready) begin
                if (acc > 0) chk("rand_interval", 64'(cyc - last_acc), 66);
                last_acc = cyc;
                exp = {32'b0, x} * {32'b0, y};
                acc++;
            end
            tick();
            cyc++;
            x = $urandom;
            y = $urandom;
            if (out_valid) begin
                chk("rand_product", product, exp);
                done++;
            end
        end
        chk("rand_done_count", 64'(done), 1000);
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spm_seq_mult.md
Name: spm_seq_mult

Overview:
Transaction-level serial-parallel multiplier built around the SPM carry-save adder chain. The parallel operand x is held across one full-adder cell per bit, each cell with its own sum and carry registers. The multiplier y is fed in serially, LSB first, and the product comes out serially from stage 0. It is the stage directly around the per-bit CSA cells: it drives their y/x inputs and consumes the serial sum they produce, and it adds the valid/ready handshake and product assembly needed by the system above.

Parameters:
SIZE, 32, operand width in bits; product is 2*SIZE bits; SIZE >= 2.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair offered.
in_ready  output  1  block can accept; high only in IDLE.
x  input  SIZE  parallel multiplicand (unsigned); sampled on acceptance.
y  input  SIZE  multiplier (unsigned); sampled on acceptance, then shifted out LSB first internally.
out_valid  output  1  product available; high only in DONE.
out_ready  input  1  consumer takes product.
product  output  2*SIZE  x*y; registered; stable while out_valid is high.
p_serial  output  1  serial product bit from stage 0 (debug/trace).
p_serial_valid  output  1  p_serial carries a product bit this cycle.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; out_valid 0, product 0, p_serial 0, p_serial_valid 0, busy 0; all CSA sum/carry regs 0; bit counter 0.
- in_ready is decoded from state (IDLE), so it is 1 in the first cycle after reset deasserts.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch x into x_reg and y into y_shift; clear all CSA sum/carry regs, counter and product shift reg; go to RUN.
  - RUN: lasts exactly 2*SIZE cycles, counter 0..2*SIZE-1.
    - Each cycle the serial y bit is y_shift[0] while counter < SIZE, and 0 otherwise; y_shift shifts right.
    - Stage i computes pp_i = x_reg[i] & ybit.
    - Full adder per stage: pp_i, sum from stage i+1 (0 into the MSB stage), carry_i.
    - Stage 0 sum is product bit number counter. It is shifted into the product shift reg from the MSB side, and also registered onto p_serial with p_serial_valid=1.
    - When counter = 2*SIZE-1: load product, go to DONE.
  - DONE: out_valid=1 and product held. On out_ready: out_valid drops next cycle; go to IDLE.
- Latency: out_valid rises 2*SIZE+1 clock edges after the acceptance edge.
- Serial output: p_serial_valid is high for exactly 2*SIZE consecutive cycles per transaction. Concatenating p_serial LSB first yields product.
- Arithmetic: unsigned, no truncation. product = x*y exactly, carries fully resolved by the 2*SIZE-th bit.
- No overlap: in_valid is ignored in RUN and DONE. The DONE->IDLE handover costs one cycle, so the minimum initiation interval is 2*SIZE+2 cycles.
- out_ready while not in DONE: ignored. in_valid and out_ready arriving in the same cycle in DONE: only the out_ready handshake takes effect.
- rst asserted mid-RUN or in DONE: transaction is discarded, all reset values apply the next cycle, and no out_valid is produced for it.
- Inputs x and y may change freely after acceptance without affecting the result.

Test Plan:
- SIZE=32, reset 2 cycles, then x=3, y=5 -> in_ready drops next cycle; out_valid after 65 edges with product=15; p_serial stream = 1,1,1,1,0...0 (64 bits).
- x=y=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001; p_serial_valid high exactly 64 cycles.
- x=0, y=32'hDEADBEEF, then x=32'h80000000, y=2 -> products 0 and 64'h1_00000000.
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid, x and y -> product and out_valid stable, in_ready=0, no new acceptance; out_ready=1 -> out_valid 0 the next cycle, in_ready 1.
- Assert rst at RUN counter=20 -> next cycle all outputs at reset values, no out_valid. New x=7, y=9 -> product=63.
- out_ready tied 1, in_valid tied 1 with random operands (1000 transactions) -> every product matches the x*y model; accepts spaced exactly 66 cycles apart.
